// File: rtl/sprite_engine.sv
// Animated sprite overlay: a 3-stage pixel pipeline fetches palette indices from an
// external ROM and composites them over the background; a small FSM steps the frame.
module sprite_engine #(
   parameter int SPR_W    = 64,
   parameter int SPR_H    = 96,
   parameter int FRAMES   = 4,
   parameter int IDX_BITS = 4,
   parameter int HOLD     = 6,
   parameter int ADDR_W   = 15,
   localparam int FRAME_W = (FRAMES > 1) ? $clog2(FRAMES) : 1
) (
   input  logic                vga_clk,
   input  logic                reset_n,
   input  logic [9:0]          draw_x,
   input  logic [9:0]          draw_y,
   input  logic                blank,
   input  logic [9:0]          spr_x,
   input  logic [9:0]          spr_y,
   input  logic                flip_h,
   input  logic [3:0]          bg_red,
   input  logic [3:0]          bg_green,
   input  logic [3:0]          bg_blue,
   input  logic                frame_tick,
   input  logic                anim_start,
   input  logic                anim_once,
   input  logic                pal_we,
   input  logic [IDX_BITS-1:0] pal_idx,
   input  logic [11:0]         pal_rgb,
   output logic [ADDR_W-1:0]   rom_addr,
   input  logic [IDX_BITS-1:0] rom_q,
   output logic [3:0]          red,
   output logic [3:0]          green,
   output logic [3:0]          blue,
   output logic [FRAME_W-1:0]  anim_frame,
   output logic                anim_done
);

   localparam int PAL_D     = 2 ** IDX_BITS;
   localparam int FRAME_PIX = SPR_W * SPR_H;
   localparam int HOLD_W    = (HOLD > 1) ? $clog2(HOLD) : 1;

   typedef enum logic [1:0] {IDLE, PLAY, DONE} state_t;

   state_t             state_q, state_d;
   logic [FRAME_W-1:0] frame_q, frame_d;
   logic [HOLD_W-1:0]  hold_q,  hold_d;

   // ---------------- animation FSM ----------------
   always_ff @(posedge vga_clk) begin
      if (!reset_n) begin
         state_q <= IDLE;
         frame_q <= '0;
         hold_q  <= '0;
      end else begin
         state_q <= state_d;
         frame_q <= frame_d;
         hold_q  <= hold_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      frame_d   = frame_q;
      hold_d    = hold_q;
      anim_done = 1'b0;
      if (state_q == DONE) anim_done = 1'b1;
      if (anim_start) begin
         state_d = PLAY;
         frame_d = '0;
         hold_d  = '0;
      end else begin
         case (state_q)
            IDLE: begin
               frame_d = '0;
               hold_d  = '0;
            end
            PLAY: begin
               if (frame_tick) begin
                  if (hold_q == HOLD_W'(HOLD - 1)) begin
                     hold_d = '0;
                     // Last frame either wraps or freezes in place for one-shot playback
                     if (frame_q == FRAME_W'(FRAMES - 1)) begin
                        if (anim_once) state_d = DONE;
                        else           frame_d = '0;
                     end else begin
                        frame_d = frame_q + FRAME_W'(1);
                     end
                  end else begin
                     hold_d = hold_q + HOLD_W'(1);
                  end
               end
            end
            DONE: ;
            default: state_d = IDLE;
         endcase
      end
   end

   assign anim_frame = frame_q;

   // ---------------- palette register file ----------------
   logic [11:0] pal_q [PAL_D];

   always_ff @(posedge vga_clk) begin
      if (!reset_n) begin
         for (int i = 0; i < PAL_D; i++) pal_q[i] <= '0;
      end else if (pal_we) begin
         pal_q[pal_idx] <= pal_rgb;
      end
   end

   // ---------------- stage 0: hit test and address ----------------
   logic [10:0]       dx_ext, dy_ext, sx_ext, sy_ext;
   logic [10:0]       lx_raw, lx, ly;
   logic              in_box;
   logic [ADDR_W-1:0] rom_addr_d;

   // Widened to 11 bits so a sprite near the right/bottom edge never wraps to column 0
   assign dx_ext = {1'b0, draw_x};
   assign dy_ext = {1'b0, draw_y};
   assign sx_ext = {1'b0, spr_x};
   assign sy_ext = {1'b0, spr_y};

   assign in_box = (dx_ext >= sx_ext) && (dx_ext < sx_ext + 11'(SPR_W)) &&
                   (dy_ext >= sy_ext) && (dy_ext < sy_ext + 11'(SPR_H));

   assign lx_raw = dx_ext - sx_ext;
   assign lx     = flip_h ? (11'(SPR_W - 1) - lx_raw) : lx_raw;
   assign ly     = dy_ext - sy_ext;

   always_comb begin
      rom_addr_d = '0;
      if (in_box)
         rom_addr_d = ADDR_W'(frame_q) * ADDR_W'(FRAME_PIX) +
                      ADDR_W'(ly) * ADDR_W'(SPR_W) + ADDR_W'(lx);
   end

   // ---------------- stages 1..3 ----------------
   logic [ADDR_W-1:0] addr_q;
   logic              inbox1_q, blank1_q, inbox2_q, blank2_q;
   logic [11:0]       bg1_q, bg2_q, rgb_q, rgb_d;

   always_ff @(posedge vga_clk) begin
      if (!reset_n) begin
         addr_q   <= '0;
         inbox1_q <= 1'b0;
         blank1_q <= 1'b0;
         bg1_q    <= '0;
         inbox2_q <= 1'b0;
         blank2_q <= 1'b0;
         bg2_q    <= '0;
         rgb_q    <= '0;
      end else begin
         addr_q   <= rom_addr_d;
         inbox1_q <= in_box;
         blank1_q <= blank;
         bg1_q    <= {bg_red, bg_green, bg_blue};
         inbox2_q <= inbox1_q;
         blank2_q <= blank1_q;
         bg2_q    <= bg1_q;
         rgb_q    <= rgb_d;
      end
   end

   // Palette index 0 is transparent and lets the background through
   always_comb begin
      rgb_d = '0;
      if (blank2_q) begin
         if (!inbox2_q || rom_q == '0) rgb_d = bg2_q;
         else                          rgb_d = pal_q[rom_q];
      end
   end

   assign rom_addr = addr_q;
   assign red      = rgb_q[11:8];
   assign green    = rgb_q[7:4];
   assign blue     = rgb_q[3:0];

endmodule

// File: tb/tb_sprite_engine.sv
// Scoreboard bench for sprite_engine: randomized pixels against an arithmetic reference
// model of the sprite/palette rules, plus directed animation and reset scenarios.
module tb_sprite_engine;
   localparam int SPR_W = 64, SPR_H = 96, FRAMES = 4, IDX_BITS = 4, HOLD = 6, ADDR_W = 15;

   logic vga_clk = 1'b0;
   always #5 vga_clk = ~vga_clk;

   logic          reset_n = 1'b0;
   logic [9:0]    draw_x = '0, draw_y = '0, spr_x = '0, spr_y = '0;
   logic          blank = 1'b0, flip_h = 1'b0;
   logic [3:0]    bg_red = '0, bg_green = '0, bg_blue = '0;
   logic          frame_tick = 1'b0, anim_start = 1'b0, anim_once = 1'b0;
   logic          pal_we = 1'b0;
   logic [3:0]    pal_idx = '0;
   logic [11:0]   pal_rgb = '0;
   logic [14:0]   rom_addr;
   logic [3:0]    rom_q = '0;
   logic [3:0]    red, green, blue;
   logic [1:0]    anim_frame;
   logic          anim_done;

   sprite_engine #(.SPR_W(SPR_W), .SPR_H(SPR_H), .FRAMES(FRAMES), .IDX_BITS(IDX_BITS),
                   .HOLD(HOLD), .ADDR_W(ADDR_W)) dut (
      .vga_clk(vga_clk), .reset_n(reset_n), .draw_x(draw_x), .draw_y(draw_y),
      .blank(blank), .spr_x(spr_x), .spr_y(spr_y), .flip_h(flip_h),
      .bg_red(bg_red), .bg_green(bg_green), .bg_blue(bg_blue),
      .frame_tick(frame_tick), .anim_start(anim_start), .anim_once(anim_once),
      .pal_we(pal_we), .pal_idx(pal_idx), .pal_rgb(pal_rgb),
      .rom_addr(rom_addr), .rom_q(rom_q), .red(red), .green(green), .blue(blue),
      .anim_frame(anim_frame), .anim_done(anim_done));

   int n_checks = 0, n_pass = 0;

   logic [3:0]  rom_mem [0:32767];
   logic [11:0] pal_m   [0:15];
   int          mdl_frame = 0, mdl_ticks = 0;
   bit          mdl_play = 0, mdl_once = 0;

   logic        stim_valid = 1'b0;
   logic [2:0]  vd = '0;
   int          q_addr[$];
   int          q_rgb[$];

   // External sprite ROM: one-cycle read latency
   always @(posedge vga_clk) rom_q <= rom_mem[rom_addr];
   always @(posedge vga_clk) vd <= {vd[1:0], stim_valid};

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: actual %0h required %0h", name, act, exp);
   endtask

   // Monitor: address appears one edge after sampling, colour three edges after
   always @(negedge vga_clk) begin
      if (vd[0]) begin
         if (q_addr.size() == 0) check("addr_queue_underflow", 1, 0);
         else check("rom_addr", int'(rom_addr), q_addr.pop_front());
      end
      if (vd[2]) begin
         if (q_rgb.size() == 0) check("rgb_queue_underflow", 1, 0);
         else check("rgb", int'({red, green, blue}), q_rgb.pop_front());
      end
   end

   task automatic pixel(input int dx, input int dy, input int sx, input int sy,
                        input bit fl, input bit bl, input int bg);
      int lx, ly, addr, exp;
      bit inb;
      @(negedge vga_clk);
      draw_x = 10'(dx); draw_y = 10'(dy); spr_x = 10'(sx); spr_y = 10'(sy);
      flip_h = fl; blank = bl;
      bg_red = 4'(bg >> 8); bg_green = 4'(bg >> 4); bg_blue = 4'(bg);
      stim_valid = 1'b1;
      inb  = (dx >= sx) && (dx < sx + SPR_W) && (dy >= sy) && (dy < sy + SPR_H);
      addr = 0;
      if (inb) begin
         lx = dx - sx;
         if (fl) lx = SPR_W - 1 - lx;
         ly = dy - sy;
         addr = mdl_frame * SPR_W * SPR_H + ly * SPR_W + lx;
      end
      if (!bl) exp = 0;
      else if (!inb || rom_mem[addr] == 4'd0) exp = bg & 'hFFF;
      else exp = int'(pal_m[rom_mem[addr]]);
      q_addr.push_back(addr);
      q_rgb.push_back(exp);
   endtask

   task automatic rand_pixel();
      int sx, sy, dx, dy;
      sx = int'($urandom_range(0, 1023));
      sy = int'($urandom_range(0, 1023));
      if ($urandom_range(0, 7) == 0) sx = int'($urandom_range(950, 1023));
      dx = sx + int'($urandom_range(0, 80)) - 8;
      dy = sy + int'($urandom_range(0, 112)) - 8;
      if (dx < 0) dx = 0;
      if (dx > 1023) dx = 1023;
      if (dy < 0) dy = 0;
      if (dy > 1023) dy = 1023;
      pixel(dx, dy, sx, sy, bit'($urandom_range(0, 1)), ($urandom_range(0, 5) != 0),
            int'($urandom_range(0, 4095)));
   endtask

   task automatic drain();
      repeat (4) begin
         @(negedge vga_clk);
         stim_valid = 1'b0;
         blank = 1'b0;
      end
   endtask

   task automatic pal_write(input int idx, input int rgb);
      @(negedge vga_clk);
      pal_we = 1'b1; pal_idx = 4'(idx); pal_rgb = 12'(rgb);
      @(negedge vga_clk);
      pal_we = 1'b0;
      pal_m[idx] = 12'(rgb);
   endtask

   // One animation control cycle, then compare against the tick-count model
   task automatic step(input bit t, input bit s);
      int ef, ed;
      @(negedge vga_clk);
      frame_tick = t; anim_start = s;
      @(negedge vga_clk);
      frame_tick = 1'b0; anim_start = 1'b0;
      if (s) begin
         mdl_play = 1; mdl_ticks = 0; mdl_once = anim_once;
      end else if (t && mdl_play) begin
         mdl_ticks++;
      end
      if (!mdl_play) ef = 0;
      else if (mdl_once) ef = (mdl_ticks / HOLD < FRAMES - 1) ? mdl_ticks / HOLD : FRAMES - 1;
      else ef = (mdl_ticks / HOLD) % FRAMES;
      ed = (mdl_play && mdl_once && mdl_ticks >= HOLD * FRAMES) ? 1 : 0;
      mdl_frame = ef;
      check("anim_frame", int'(anim_frame), ef);
      check("anim_done", int'(anim_done), ed);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: actual timeout required finish");
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < 32768; i++)
         rom_mem[i] = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'(($urandom_range(1, 15)));
      rom_mem[0]  = 4'd5;
      rom_mem[10] = 4'd0;
      for (int i = 0; i < 16; i++) pal_m[i] = '0;

      repeat (3) @(negedge vga_clk);
      check("reset_frame", int'(anim_frame), 0);
      check("reset_done", int'(anim_done), 0);
      check("reset_addr", int'(rom_addr), 0);
      check("reset_rgb", int'({red, green, blue}), 0);
      reset_n = 1'b1;

      for (int i = 0; i < 16; i++) pal_write(i, int'($urandom_range(0, 4095)));
      pal_write(5, 'hF80);

      // Directed pixels at frame 0
      pixel(100, 50, 100, 50, 0, 1, 'h123);
      pixel(100, 51, 100, 50, 1, 1, 'h456);
      pixel(164, 50, 100, 50, 0, 1, 'h9AB);
      pixel(110, 50, 100, 50, 0, 1, 'h345);
      pixel(110, 50, 100, 50, 0, 0, 'h345);
      pixel(163, 145, 100, 50, 0, 1, 'h111);
      pixel(99, 50, 100, 50, 0, 1, 'h222);
      pixel(100, 146, 100, 50, 0, 1, 'h333);
      pixel(1023, 1000, 1000, 990, 1, 1, 'h444);
      repeat (150) rand_pixel();
      drain();

      // Looping animation: 24 ticks walk all frames and wrap to 0
      anim_once = 1'b0;
      step(0, 1);
      repeat (24) step(1, 0);
      repeat (13) step(1, 0);
      repeat (150) rand_pixel();
      drain();

      // One-shot animation ends parked on the last frame
      anim_once = 1'b1;
      step(0, 1);
      repeat (24) step(1, 0);
      repeat (3) step(1, 0);
      repeat (100) rand_pixel();
      drain();
      step(1, 1);
      repeat (7) step(1, 0);

      // Reset in the middle of playback at frame 2
      anim_once = 1'b0;
      step(0, 1);
      repeat (12) step(1, 0);
      @(negedge vga_clk);
      reset_n = 1'b0;
      frame_tick = 1'b1;
      draw_x = 10'd0; draw_y = 10'd0; spr_x = 10'd500; spr_y = 10'd500;
      blank = 1'b1; bg_red = 4'hA; bg_green = 4'hB; bg_blue = 4'hC;
      @(negedge vga_clk);
      frame_tick = 1'b0;
      check("rst_frame", int'(anim_frame), 0);
      check("rst_done", int'(anim_done), 0);
      check("rst_addr", int'(rom_addr), 0);
      check("rst_rgb", int'({red, green, blue}), 0);
      reset_n = 1'b1;
      mdl_play = 0; mdl_ticks = 0; mdl_frame = 0;
      for (int i = 0; i < 16; i++) pal_m[i] = '0;
      @(negedge vga_clk);
      check("rst_rgb_r1", int'({red, green, blue}), 0);
      @(negedge vga_clk);
      check("rst_rgb_r2", int'({red, green, blue}), 0);
      @(negedge vga_clk);
      check("rst_rgb_r3", int'({red, green, blue}), 'hABC);
      drain();
      repeat (6) step(1, 0);
      repeat (100) rand_pixel();
      drain();
      for (int i = 1; i < 16; i++) pal_write(i, int'($urandom_range(0, 4095)));
      repeat (100) rand_pixel();
      drain();

      check("scoreboard_empty", q_addr.size() + q_rgb.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/sprite_engine.md
SPRITE_ENGINE -- requirements
Module: sprite_engine

Interface
REQ-001 SHALL have parameter SPR_W, default 64: sprite width in pixels.
REQ-002 SHALL have parameter SPR_H, default 96: sprite height in pixels.
REQ-003 SHALL have parameter FRAMES, default 4: animation frames stored back-to-back in ROM.
REQ-004 SHALL have parameter IDX_BITS, default 4: palette index width; palette depth = 2**IDX_BITS.
REQ-005 SHALL have parameter HOLD, default 6: frame_tick pulses per animation frame.
REQ-006 SHALL have parameter ADDR_W, default 15: ROM address width; must hold FRAMES*SPR_W*SPR_H-1.
REQ-007 SHALL have port vga_clk, in, 1: single clock; all logic on posedge.
REQ-008 SHALL have port reset_n, in, 1: synchronous, active-low reset.
REQ-009 SHALL have port draw_x / draw_y, in, 10 each: current pixel coordinate.
REQ-010 SHALL have port blank, in, 1: 1 = active video, 0 = blanking.
REQ-011 SHALL have port spr_x / spr_y, in, 10 each: sprite top-left position.
REQ-012 SHALL have port flip_h, in, 1: mirror sprite horizontally.
REQ-013 SHALL have port bg_red / bg_green / bg_blue, in, 4 each: background pixel, aligned with draw_x.
REQ-014 SHALL have port frame_tick, in, 1: one-cycle pulse per video frame.
REQ-015 SHALL have port anim_start, in, 1: one-cycle pulse, restart animation.
REQ-016 SHALL have port anim_once, in, 1: 0 = loop, 1 = play once and stop.
REQ-017 SHALL have ports pal_we (1), pal_idx (IDX_BITS), pal_rgb (12), in: palette write, {r,g,b}.
REQ-018 SHALL have port rom_addr, out, ADDR_W: registered ROM address.
REQ-019 SHALL have port rom_q, in, IDX_BITS: ROM data, valid exactly one cycle after rom_addr.
REQ-020 SHALL have ports red / green / blue, out, 4 each: registered pixel output.
REQ-021 SHALL have port anim_frame, out, clog2(FRAMES): current frame; port anim_done, out, 1.

Function
REQ-022 SHALL compute in-box = (spr_x <= draw_x < spr_x+SPR_W) and (spr_y <= draw_y < spr_y+SPR_H), with 11-bit compares (no wrap).
REQ-023 SHALL form lx = draw_x-spr_x, or SPR_W-1-lx when flip_h; ly = draw_y-spr_y.
REQ-024 SHALL register rom_addr = anim_frame*SPR_W*SPR_H + ly*SPR_W + lx at cycle 1; rom_addr = 0 when not in-box.
REQ-025 SHALL delay blank, in-box and bg_* by two register stages to align with rom_q at cycle 2.
REQ-026 SHALL drive output at cycle 3 (fixed 3-cycle latency from draw_x/draw_y to red/green/blue).
REQ-027 SHALL output 0,0,0 when delayed blank = 0.
REQ-028 SHALL output bg_* when blank = 1 and (not in-box or rom_q = 0), because index 0 is transparent.
REQ-029 SHALL otherwise output palette[rom_q].
REQ-030 SHALL hold a 2**IDX_BITS x 12 palette register file written on pal_we; a write and a read of the same index in the same cycle return the old value.
REQ-031 SHALL implement an animation FSM with states IDLE, PLAY and DONE.
REQ-032 IDLE: anim_frame = 0; anim_start -> PLAY with hold counter = 0.
REQ-033 PLAY: each frame_tick increments the hold counter; at HOLD-1 it clears and advances anim_frame.
REQ-034 PLAY: at the advance from FRAMES-1, go to frame 0 if anim_once = 0; if anim_once = 1, stay at FRAMES-1 and go to DONE.
REQ-035 DONE: anim_done = 1; anim_start -> PLAY at frame 0 with hold counter = 0.
REQ-036 anim_start SHALL take priority over a simultaneous frame_tick, in any state.
REQ-037 anim_frame SHALL change only on a frame_tick or anim_start cycle; the pixel pipeline samples it at stage 1.

Reset
REQ-038 With reset_n = 0 at a posedge, SHALL set: FSM = IDLE, anim_frame = 0, hold counter = 0, anim_done = 0, rom_addr = 0, red/green/blue = 0, all pipeline valid/blank stages = 0.
REQ-039 Palette contents SHALL be cleared to 0 by reset.
REQ-040 Reset mid-animation SHALL abort with no pending advance; no output differs from 0 until 3 cycles after reset release.

Verification
REQ-041 SHALL cover: spr=(100,50), draw=(100,50), blank=1, frame 0 -> rom_addr=0 at cycle 1; with rom_q=5 and palette[5]=12'hF80 -> red/green/blue=F,8,0 at cycle 3.
REQ-042 SHALL cover: flip_h=1, draw=(100,51) -> rom_addr=1*64+63=127; draw=(164,50) -> out-of-box, bg_* passes through.
REQ-043 SHALL cover: rom_q=0 in-box with bg=(3,4,5) -> output 3,4,5; same pixel with blank=0 -> output 0,0,0.
REQ-044 SHALL cover: anim_once=0, HOLD=6, anim_start, then 24 frame_ticks -> frames 0,1,2,3 each for 6 ticks, then back to 0.
REQ-045 SHALL cover: anim_once=1 -> after 24 ticks anim_frame=3 and anim_done=1; anim_start plus frame_tick in the same cycle -> PLAY, frame 0, hold counter=0.
REQ-046 SHALL cover: reset_n=0 during PLAY at frame 2 -> next cycle anim_frame=0, IDLE, RGB=0.
